// File: rtl/rename_reg_file.sv
// Rename register file (V/Q tables): dual commit with tag elimination, zero-cycle bypassed reads.
// Checkpoint stack for branch recovery is built only when RF_CKPT_EN is defined.
module rename_reg_file #(
  parameter int XLEN     = 32,
  parameter int REG_NUM  = 32,
  parameter int ROB_W    = 4,
  parameter int RD_PORTS = 2,
  parameter int CKPT_NUM = 4,
  localparam int RW = $clog2(REG_NUM),
  localparam int CW = $clog2(CKPT_NUM)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [RD_PORTS*RW-1:0]    rd_idx,
  output logic [RD_PORTS*XLEN-1:0]  rd_V,
  output logic [RD_PORTS*ROB_W-1:0] rd_Q,
  input  logic                      alloc_en,
  input  logic [RW-1:0]             alloc_rd,
  input  logic [ROB_W-1:0]          alloc_Q,
  input  logic [1:0]                cmt_en,
  input  logic [2*RW-1:0]           cmt_rd,
  input  logic [2*ROB_W-1:0]        cmt_Q,
  input  logic [2*XLEN-1:0]         cmt_V,
  input  logic                      flush,
  input  logic                      ckpt_save,
  output logic [CW-1:0]             ckpt_save_id,
  output logic                      ckpt_full,
  input  logic                      ckpt_restore,
  input  logic [CW-1:0]             ckpt_restore_id,
  input  logic                      ckpt_release
);
  typedef logic [ROB_W-1:0] tag_t;
  typedef logic [RW-1:0]    idx_t;

  logic [XLEN-1:0] v_q   [REG_NUM];
  logic [XLEN-1:0] v_nxt [REG_NUM];
  tag_t            q_q   [REG_NUM];
  tag_t            q_nxt [REG_NUM];
  tag_t            rest_q[REG_NUM];

  idx_t            c_rd  [2];
  tag_t            c_tag [2];
  logic [XLEN-1:0] c_val [2];
  logic [1:0]      c_wr;
  logic [1:0]      c_elim;
  logic            alloc_act;
  logic            restore_act;

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      c_rd[p]  = cmt_rd[p*RW +: RW];
      c_tag[p] = cmt_Q[p*ROB_W +: ROB_W];
      c_val[p] = cmt_V[p*XLEN +: XLEN];
      c_wr[p]  = cmt_en[p] && (cmt_rd[p*RW +: RW] != '0);
    end
    // same destination on both ports: only the younger tag may eliminate
    c_elim[1] = c_wr[1];
    c_elim[0] = c_wr[0] && !(c_wr[1] && (c_rd[1] == c_rd[0]));
  end

  function automatic tag_t apply_elim(input tag_t cur, input idx_t r);
    tag_t res;
    res = cur;
    for (int p = 0; p < 2; p++)
      if (c_elim[p] && (c_rd[p] == r) && (c_tag[p] == cur))
        res = '0;
    return res;
  endfunction

  assign alloc_act = alloc_en && (alloc_rd != '0) && !flush && !restore_act;

  always_comb begin
    for (int r = 0; r < REG_NUM; r++) begin
      q_nxt[r] = apply_elim(q_q[r], idx_t'(r));
      if (alloc_act && (alloc_rd == idx_t'(r)))
        q_nxt[r] = alloc_Q;
      if (restore_act)
        q_nxt[r] = rest_q[r];
      if (flush || (r == 0))
        q_nxt[r] = '0;
      v_nxt[r] = v_q[r];
      if (c_wr[0] && (c_rd[0] == idx_t'(r)))
        v_nxt[r] = c_val[0];
      if (c_wr[1] && (c_rd[1] == idx_t'(r)))
        v_nxt[r] = c_val[1];
      if (r == 0)
        v_nxt[r] = '0;
    end
  end

  // Reads see this cycle's writes; outputs are held at zero while reset is asserted.
  always_comb begin
    rd_V = '0;
    rd_Q = '0;
    if (rst) begin
      for (int c = 0; c < RD_PORTS; c++) begin
        rd_V[c*XLEN +: XLEN]   = v_nxt[rd_idx[c*RW +: RW]];
        rd_Q[c*ROB_W +: ROB_W] = q_nxt[rd_idx[c*RW +: RW]];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < REG_NUM; r++) begin
        v_q[r] <= '0;
        q_q[r] <= '0;
      end
    end else begin
      for (int r = 0; r < REG_NUM; r++) begin
        v_q[r] <= v_nxt[r];
        q_q[r] <= q_nxt[r];
      end
    end
  end

`ifdef RF_CKPT_EN
  tag_t          ckpt_q [CKPT_NUM][REG_NUM];
  logic [CW-1:0] head_q;
  logic [CW-1:0] tail_q;
  logic [CW:0]   cnt_q;
  logic          save_act;
  logic          rel_act;

  assign restore_act  = ckpt_restore && !flush;
  assign ckpt_full    = (cnt_q == (CW+1)'(CKPT_NUM));
  assign ckpt_save_id = tail_q;
  assign save_act     = ckpt_save && !flush && !restore_act && !ckpt_full;
  assign rel_act      = ckpt_release && !flush && !restore_act && (cnt_q != '0);

  always_comb begin
    for (int r = 0; r < REG_NUM; r++)
      rest_q[r] = apply_elim(ckpt_q[ckpt_restore_id][r], idx_t'(r));
  end

  // Elimination touches every slot; a dead slot is always rewritten by its next save.
  always_ff @(posedge clk) begin
    for (int s = 0; s < CKPT_NUM; s++)
      for (int r = 0; r < REG_NUM; r++)
        ckpt_q[s][r] <= (save_act && (tail_q == CW'(s))) ? q_nxt[r]
                                                          : apply_elim(ckpt_q[s][r], idx_t'(r));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else if (flush) begin
      head_q <= tail_q;
      cnt_q  <= '0;
    end else if (restore_act) begin
      tail_q <= ckpt_restore_id + 1'b1;
      cnt_q  <= {1'b0, ckpt_restore_id - head_q} + 1'b1;
    end else begin
      if (save_act)
        tail_q <= tail_q + 1'b1;
      if (rel_act)
        head_q <= head_q + 1'b1;
      if (save_act && !rel_act)
        cnt_q <= cnt_q + 1'b1;
      else if (rel_act && !save_act)
        cnt_q <= cnt_q - 1'b1;
    end
  end
`else
  logic unused_ckpt;

  assign restore_act  = 1'b0;
  assign ckpt_full    = 1'b1;
  assign ckpt_save_id = '0;
  assign unused_ckpt  = ^{ckpt_save, ckpt_restore, ckpt_restore_id, ckpt_release};

  always_comb begin
    for (int r = 0; r < REG_NUM; r++)
      rest_q[r] = '0;
  end
`endif

endmodule

// File: tb/tb_rename_reg_file.sv
// Directed + random checks of rename_reg_file against a table-level reference model.
module tb_rename_reg_file;
`ifdef RF_CKPT_EN
  localparam bit CKPT = 1'b1;
`else
  localparam bit CKPT = 1'b0;
`endif
  localparam int NCK = 4;

  logic        clk;
  logic        rst;
  logic [9:0]  rd_idx;
  logic [63:0] rd_V;
  logic [7:0]  rd_Q;
  logic        alloc_en;
  logic [4:0]  alloc_rd;
  logic [3:0]  alloc_Q;
  logic [1:0]  cmt_en;
  logic [9:0]  cmt_rd;
  logic [7:0]  cmt_Q;
  logic [63:0] cmt_V;
  logic        flush;
  logic        ckpt_save;
  logic [1:0]  ckpt_save_id;
  logic        ckpt_full;
  logic        ckpt_restore;
  logic [1:0]  ckpt_restore_id;
  logic        ckpt_release;

  int checks;
  int failures;

  // reference state: value/tag tables, snapshot slots, circular stack bookkeeping
  logic [31:0] mV[32];
  int          mQ[32];
  int          mS[NCK][32];
  int          mHead, mTail, mCnt;

  rename_reg_file dut (
    .clk(clk), .rst(rst), .rd_idx(rd_idx), .rd_V(rd_V), .rd_Q(rd_Q),
    .alloc_en(alloc_en), .alloc_rd(alloc_rd), .alloc_Q(alloc_Q),
    .cmt_en(cmt_en), .cmt_rd(cmt_rd), .cmt_Q(cmt_Q), .cmt_V(cmt_V),
    .flush(flush), .ckpt_save(ckpt_save), .ckpt_save_id(ckpt_save_id),
    .ckpt_full(ckpt_full), .ckpt_restore(ckpt_restore),
    .ckpt_restore_id(ckpt_restore_id), .ckpt_release(ckpt_release)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    alloc_en = 1'b0; alloc_rd = '0; alloc_Q = '0;
    cmt_en = '0; cmt_rd = '0; cmt_Q = '0; cmt_V = '0;
    flush = 1'b0; ckpt_save = 1'b0; ckpt_restore = 1'b0;
    ckpt_restore_id = '0; ckpt_release = 1'b0;
  endtask

  task automatic rd(input int c0, input int c1);
    rd_idx = {5'(c1), 5'(c0)};
  endtask

  task automatic alloc(input int r, input int t);
    alloc_en = 1'b1; alloc_rd = 5'(r); alloc_Q = 4'(t);
  endtask

  task automatic cm(input int p, input int r, input int t, input logic [31:0] v);
    cmt_en[p] = 1'b1;
    cmt_rd[p*5 +: 5] = 5'(r);
    cmt_Q[p*4 +: 4] = 4'(t);
    cmt_V[p*32 +: 32] = v;
  endtask

  task automatic model_reset();
    for (int r = 0; r < 32; r++) begin
      mV[r] = '0;
      mQ[r] = 0;
    end
    mHead = 0; mTail = 0; mCnt = 0;
  endtask

  // Predict this cycle's outputs and next state from the current inputs, check, then clock.
  task automatic step();
    logic [31:0] nV[32];
    int nQ[32];
    int nS[NCK][32];
    int r0, r1, t0, t1, ar, rid, idx;
    bit w0, w1, e0, rest, sv, rl;
    int nHead, nTail, nCnt;
    r0 = int'(cmt_rd[4:0]); r1 = int'(cmt_rd[9:5]);
    t0 = int'(cmt_Q[3:0]);  t1 = int'(cmt_Q[7:4]);
    ar = int'(alloc_rd); rid = int'(ckpt_restore_id);
    w0 = cmt_en[0] && r0 != 0;
    w1 = cmt_en[1] && r1 != 0;
    e0 = w0 && !(w1 && r1 == r0);
    rest = CKPT && ckpt_restore && !flush;
    nV = mV; nQ = mQ; nS = mS;
    if (w0) nV[r0] = cmt_V[31:0];
    if (w1) nV[r1] = cmt_V[63:32];
    // a committed tag disappears from the table and from every snapshot still holding it
    if (w1 && mQ[r1] == t1) nQ[r1] = 0;
    if (e0 && mQ[r0] == t0) nQ[r0] = 0;
    for (int s = 0; s < NCK; s++) begin
      if (w1 && mS[s][r1] == t1) nS[s][r1] = 0;
      if (e0 && mS[s][r0] == t0) nS[s][r0] = 0;
    end
    if (rest) begin
      for (int r = 0; r < 32; r++) nQ[r] = nS[rid][r];
    end else if (alloc_en && ar != 0 && !flush) begin
      nQ[ar] = int'(alloc_Q);
    end
    if (flush) for (int r = 0; r < 32; r++) nQ[r] = 0;
    sv = CKPT && ckpt_save && !flush && !rest && mCnt < NCK;
    rl = CKPT && ckpt_release && !flush && !rest && mCnt > 0;
    if (sv) for (int r = 0; r < 32; r++) nS[mTail][r] = nQ[r];
    nHead = mHead; nTail = mTail; nCnt = mCnt;
    if (flush) begin
      nHead = mTail; nCnt = 0;
    end else if (rest) begin
      nTail = (rid + 1) % NCK;
      nCnt = (rid - mHead + NCK) % NCK + 1;
    end else begin
      nTail = (mTail + int'(sv)) % NCK;
      nHead = (mHead + int'(rl)) % NCK;
      nCnt = mCnt + int'(sv) - int'(rl);
    end
    #2;
    for (int c = 0; c < 2; c++) begin
      idx = int'(rd_idx[c*5 +: 5]);
      chk("rd_V", rd_V[c*32 +: 32], (idx == 0) ? 32'h0 : nV[idx]);
      chk("rd_Q", 32'(rd_Q[c*4 +: 4]), (idx == 0) ? 32'h0 : 32'(nQ[idx]));
    end
    chk("ckpt_full", 32'(ckpt_full), CKPT ? 32'(mCnt == NCK) : 32'h1);
    chk("ckpt_save_id", 32'(ckpt_save_id), CKPT ? 32'(mTail) : 32'h0);
    @(posedge clk);
    #1;
    mV = nV; mQ = nQ; mS = nS;
    mHead = nHead; mTail = nTail; mCnt = nCnt;
  endtask

  initial begin
    int saved_id;
    int r, t;
    checks = 0;
    failures = 0;
    for (int s = 0; s < NCK; s++)
      for (int k = 0; k < 32; k++) mS[s][k] = 0;
    model_reset();
    rst = 1'b0;
    clr();
    rd(5, 0);
    alloc(5, 3);
    #1;
    chk("reset_rd_V", rd_V[31:0], 32'h0);
    chk("reset_rd_Q", 32'(rd_Q[3:0]), 32'h0);
    chk("reset_full", 32'(ckpt_full), CKPT ? 32'h0 : 32'h1);
    chk("reset_save_id", 32'(ckpt_save_id), 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    clr();

    // read, alloc bypass, commit bypass with elimination
    rd(5, 0); step();
    alloc(5, 3); step();
    clr(); step();
    cm(0, 5, 3, 32'hDEAD); step();
    clr(); step();

    // stale commit leaves the younger tag in place
    rd(7, 0);
    alloc(7, 2); step();
    alloc(7, 5); step();
    clr(); cm(0, 7, 2, 32'h1); step();
    clr(); step();

    // dual commit to the same register: port 1 value and tag decide
    rd(9, 0);
    alloc(9, 4); step();
    clr(); cm(0, 9, 1, 32'd10); cm(1, 9, 4, 32'd20); step();
    clr(); step();

    // two snapshots, then recover to the older one
    rd(3, 4);
    alloc(3, 6); ckpt_save = 1'b1; step();
    clr(); alloc(3, 7); ckpt_save = 1'b1; step();
    clr(); alloc(4, 8); step();
    clr(); ckpt_restore = 1'b1; ckpt_restore_id = 2'd0; step();
    clr(); step();

    // fill the stack, overflow, release, save+release together
    clr(); ckpt_release = 1'b1; step();
    clr();
    for (int i = 0; i < 5; i++) begin
      ckpt_save = 1'b1; step();
    end
    clr(); step();
    ckpt_release = 1'b1; step();
    clr(); ckpt_save = 1'b1; ckpt_release = 1'b1; step();
    clr(); step();

    // committed tag must not come back through a restore
    flush = 1'b1; step();
    clr(); rd(2, 0);
    alloc(2, 9); step();
    clr(); saved_id = mTail; ckpt_save = 1'b1; step();
    clr(); cm(0, 2, 9, 32'h55); step();
    clr(); ckpt_restore = 1'b1; ckpt_restore_id = 2'(saved_id); step();
    clr(); step();
    alloc(6, 11); step();
    clr(); flush = 1'b1; alloc(8, 12); step();
    clr();
    for (int k = 0; k < 32; k += 2) begin
      rd(k, k + 1); step();
    end

    // randomized traffic on a small register window so tags collide often
    for (int i = 0; i < 1500; i++) begin
      clr();
      rd($urandom_range(0, 7), $urandom_range(0, 7));
      if ($urandom % 2 == 0) alloc($urandom_range(0, 7), $urandom_range(1, 15));
      for (int p = 0; p < 2; p++) begin
        if ($urandom % 3 == 0) begin
          r = $urandom_range(0, 7);
          t = ($urandom % 2 == 0) ? mQ[r] : $urandom_range(1, 15);
          cm(p, r, t, $urandom);
        end
      end
      if ($urandom % 40 == 0) flush = 1'b1;
      if ($urandom % 4 == 0) ckpt_save = 1'b1;
      if ($urandom % 4 == 0) ckpt_release = 1'b1;
      if ($urandom % 16 == 0 && (mCnt > 0 || !CKPT)) begin
        ckpt_restore = 1'b1;
        ckpt_restore_id = (mCnt > 0) ? 2'((mHead + $urandom % mCnt) % NCK) : 2'($urandom % NCK);
      end
      step();
    end

    // asynchronous reset in the middle of a pending alloc/commit
    clr(); rd(3, 0); alloc(3, 5); cm(0, 3, 2, 32'h77);
    rst = 1'b0;
    #1;
    chk("midreset_rd_V", rd_V[31:0], 32'h0);
    chk("midreset_rd_Q", 32'(rd_Q[3:0]), 32'h0);
    chk("midreset_save_id", 32'(ckpt_save_id), 32'h0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    clr(); step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
